// File: rtl/ic_fill_ctrl_pkg.sv
// Shared icache fill types: FSM states, default geometry and address-field helpers.
// Pure definitions with no logic, no latency, no flow control.
package ic_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_FIN  = 2'd3
    } ic_state_e;

    localparam int IC_IWIDTH = 14;
    localparam int IC_LWIDTH = 2;

    // The line index sits between the beat field and the tag in the fetch PC.
    function automatic int ic_idx_lo(input int lw);
        return lw + 4;
    endfunction

    function automatic int ic_idx_hi(input int iw);
        return iw + 1;
    endfunction

    function automatic int ic_tag_lo(input int iw);
        return iw + 2;
    endfunction

endpackage

// File: rtl/ic_fill_ctrl_tag_ram.sv
// Icache tag array: asynchronous read, synchronous write, contents are not reset.
// Zero-latency read and single-cycle write, with no flow control.
module ic_tag_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ic_fill_ctrl.sv
// Icache miss handler: tag lookup, DRAM line request and beat-indexed refill, with stall timing for IF.
// Stall asserts in the miss cycle; the request is held until ready; beats are taken whenever valid.
module ic_fill_ctrl
    import ic_fill_ctrl_pkg::*;
#(
    parameter int IWIDTH = IC_IWIDTH,
    parameter int LWIDTH = IC_LWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:2]       pc_if,
    input  logic              fetch_en,
    input  logic              ic_flush,
    output logic              ic_req_m_valid,
    input  logic              ic_req_m_ready,
    output logic [27:0]       ic_req_m_adr,
    input  logic              ic_rdat_m_valid,
    output logic [IWIDTH-3:0] ic_ram_wadr_all,
    output logic              ic_stall,
    output logic              ic_stall_dly,
    output logic              ic_stall_fin,
    output logic              ic_stall_fin2
);

    localparam int IDXW  = IWIDTH - 2 - LWIDTH;
    localparam int TAGW  = 30 - IWIDTH;
    localparam int NLINE = 1 << IDXW;

    logic [IDXW-1:0]   pc_idx;
    logic [TAGW-1:0]   pc_tag;
    logic [TAGW-1:0]   rd_tag;
    logic              unused_pc_bits;
    logic              hit;
    logic              miss;
    logic              tag_we;

    ic_state_e         state_q, state_d;
    logic              req_vld_q, req_vld_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [LWIDTH-1:0] beat_q, beat_d;
    logic [NLINE-1:0]  valid_q, valid_d;
    logic              flush_pend_q, flush_pend_d;
    logic              stall_dly_q, stall_dly_d;
    logic              fin_q, fin_d;
    logic              fin2_q, fin2_d;

    assign pc_idx         = pc_if[ic_idx_hi(IWIDTH):ic_idx_lo(LWIDTH)];
    assign pc_tag         = pc_if[31:ic_tag_lo(IWIDTH)];
    assign unused_pc_bits = ^pc_if[LWIDTH+3:2];

    ic_tag_ram #(
        .AW (IDXW),
        .DW (TAGW)
    ) u_tag_ram (
        .clk   (clk),
        .we    (tag_we),
        .waddr (idx_q),
        .wdata (tag_q),
        .raddr (pc_idx),
        .rdata (rd_tag)
    );

    assign hit  = valid_q[pc_idx] && (rd_tag == pc_tag);
    assign miss = fetch_en && !hit;

    always_comb begin
        state_d      = state_q;
        req_vld_d    = req_vld_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        fin_d        = 1'b0;
        tag_we       = 1'b0;
        ic_stall     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ic_stall = miss;
                if (ic_flush) begin
                    valid_d = '0;
                end
                if (miss) begin
                    state_d   = ST_REQ;
                    req_vld_d = 1'b1;
                    tag_d     = pc_tag;
                    idx_d     = pc_idx;
                end
            end
            ST_REQ: begin
                ic_stall = 1'b1;
                if (ic_flush) begin
                    flush_pend_d = 1'b1;
                end
                // Beats seen before the accept edge are not part of this line.
                if (ic_req_m_ready) begin
                    state_d   = ST_FILL;
                    req_vld_d = 1'b0;
                    beat_d    = '0;
                end
            end
            ST_FILL: begin
                ic_stall = 1'b1;
                if (ic_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (ic_rdat_m_valid) begin
                    beat_d = beat_q + LWIDTH'(1);
                    if (&beat_q) begin
                        tag_we       = 1'b1;
                        state_d      = ST_FIN;
                        fin_d        = 1'b1;
                        flush_pend_d = 1'b0;
                        // A flush raised during the fill leaves the new line invalid too.
                        if (flush_pend_q || ic_flush) begin
                            valid_d = '0;
                        end else begin
                            valid_d[idx_q] = 1'b1;
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                if (ic_flush) begin
                    valid_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        stall_dly_d = ic_stall;
        fin2_d      = fin_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_vld_q    <= 1'b0;
            tag_q        <= '0;
            idx_q        <= '0;
            beat_q       <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            stall_dly_q  <= 1'b0;
            fin_q        <= 1'b0;
            fin2_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_vld_q    <= req_vld_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            stall_dly_q  <= stall_dly_d;
            fin_q        <= fin_d;
            fin2_q       <= fin2_d;
        end
    end

    assign ic_req_m_valid  = req_vld_q;
    assign ic_req_m_adr    = {tag_q, idx_q, {LWIDTH{1'b0}}};
    assign ic_ram_wadr_all = {idx_q, beat_q};
    assign ic_stall_dly    = stall_dly_q;
    assign ic_stall_fin    = fin_q;
    assign ic_stall_fin2   = fin2_q;

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Self-checking bench for ic_fill_ctrl: scoreboarded request addresses and refill write indices.
// Stimulus is driven 1 time unit after posedge and outputs are sampled on negedge.
module tb_ic_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:2] pc_if;
    logic        fetch_en;
    logic        ic_flush;
    logic        ic_req_m_valid;
    logic        ic_req_m_ready;
    logic [27:0] ic_req_m_adr;
    logic        ic_rdat_m_valid;
    logic [11:0] ic_ram_wadr_all;
    logic        ic_stall;
    logic        ic_stall_dly;
    logic        ic_stall_fin;
    logic        ic_stall_fin2;

    int chk_cnt  = 0;
    int fail_cnt = 0;

    logic [27:0] req_q[$];
    logic [11:0] wadr_q[$];

    ic_fill_ctrl #(.IWIDTH(14), .LWIDTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_if           (pc_if),
        .fetch_en        (fetch_en),
        .ic_flush        (ic_flush),
        .ic_req_m_valid  (ic_req_m_valid),
        .ic_req_m_ready  (ic_req_m_ready),
        .ic_req_m_adr    (ic_req_m_adr),
        .ic_rdat_m_valid (ic_rdat_m_valid),
        .ic_ram_wadr_all (ic_ram_wadr_all),
        .ic_stall        (ic_stall),
        .ic_stall_dly    (ic_stall_dly),
        .ic_stall_fin    (ic_stall_fin),
        .ic_stall_fin2   (ic_stall_fin2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumers: request accept and refill beat writes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ic_req_m_valid && ic_req_m_ready) begin
                if (req_q.size() == 0) chk("req_pending", 32'(req_q.size()), 1);
                else                   chk("req_adr", 32'(ic_req_m_adr), 32'(req_q.pop_front()));
            end
            if (ic_rdat_m_valid && ic_stall && ic_stall_dly && !ic_req_m_valid) begin
                if (wadr_q.size() == 0) chk("wadr_pending", 32'(wadr_q.size()), 1);
                else                    chk("wadr", 32'(ic_ram_wadr_all), 32'(wadr_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [31:0] pcb, input logic exp_stall, input string tag);
        pc_if    = pcb[31:2];
        fetch_en = 1'b1;
        @(negedge clk);
        chk(tag, 32'(ic_stall), 32'(exp_stall));
        fetch_en = 1'b0;
        step();
    endtask

    task automatic do_fill(input logic [31:0] pcb, input int rdly, input logic [7:0] pat,
                           input int plen, input int fl_beat, input logic exp_miss_after);
        int sent;
        int k;
        logic b;
        pc_if    = pcb[31:2];
        fetch_en = 1'b1;
        req_q.push_back({pcb[31:6], 2'b00});
        @(negedge clk);
        chk("miss_stall", 32'(ic_stall), 1);
        chk("miss_noreq", 32'(ic_req_m_valid), 0);
        step();
        fetch_en = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            ic_rdat_m_valid = 1'b1;
            @(negedge clk);
            chk("bp_req_vld", 32'(ic_req_m_valid), 1);
            chk("bp_adr", 32'(ic_req_m_adr), 32'({pcb[31:6], 2'b00}));
            chk("bp_stall", 32'(ic_stall), 1);
            step();
        end
        ic_rdat_m_valid = 1'b0;
        ic_req_m_ready  = 1'b1;
        @(negedge clk);
        chk("req_stall_dly", 32'(ic_stall_dly), 1);
        step();
        ic_req_m_ready = 1'b0;
        sent = 0;
        k    = 0;
        while (sent < 4 && k < 64) begin
            b = (k < plen) ? pat[k] : 1'b1;
            ic_rdat_m_valid = b;
            ic_flush        = 1'b0;
            if (b) begin
                wadr_q.push_back({pcb[15:6], 2'(sent)});
                ic_flush = (sent == fl_beat);
                sent++;
            end
            step();
            k++;
        end
        ic_rdat_m_valid = 1'b0;
        ic_flush        = 1'b0;
        @(negedge clk);
        chk("fin", 32'(ic_stall_fin), 1);
        chk("fin_fin2", 32'(ic_stall_fin2), 0);
        chk("fin_stall", 32'(ic_stall), 0);
        chk("fin_req", 32'(ic_req_m_valid), 0);
        step();
        fetch_en = 1'b1;
        @(negedge clk);
        chk("fin2", 32'(ic_stall_fin2), 1);
        chk("fin2_fin", 32'(ic_stall_fin), 0);
        chk("fin2_stall_dly", 32'(ic_stall_dly), 0);
        chk("relookup_stall", 32'(ic_stall), 32'(exp_miss_after));
        fetch_en = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        pc_if           = '0;
        fetch_en        = 1'b0;
        ic_flush        = 1'b0;
        ic_req_m_ready  = 1'b0;
        ic_rdat_m_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_vld", 32'(ic_req_m_valid), 0);
        chk("rst_stall", 32'(ic_stall), 0);
        chk("rst_stall_dly", 32'(ic_stall_dly), 0);
        chk("rst_fin", 32'(ic_stall_fin), 0);
        chk("rst_fin2", 32'(ic_stall_fin2), 0);
        chk("rst_wadr", 32'(ic_ram_wadr_all), 0);
        step();
        rst_n = 1'b1;
        step();

        // Cold miss, then hit.
        do_fill(32'h0000_0100, 0, 8'hFF, 0, -1, 1'b0);
        probe(32'h0000_0100, 1'b0, "hit_0x100");

        // Backpressure with early beats, conflicting tag on index 4.
        do_fill(32'h0001_0100, 5, 8'hFF, 0, -1, 1'b0);
        probe(32'h0000_0100, 1'b1, "conflict_miss_0x100");

        // Gapped beats 1,0,0,1,1,0,1.
        do_fill(32'h0000_0100, 0, 8'h59, 7, -1, 1'b0);
        do_fill(32'h0000_0200, 0, 8'hFF, 0, -1, 1'b0);
        probe(32'h0000_0100, 1'b0, "hit2_0x100");

        // Flush while idle invalidates every line.
        ic_flush = 1'b1;
        step();
        ic_flush = 1'b0;
        probe(32'h0000_0100, 1'b1, "idle_flush_0x100");
        probe(32'h0000_0200, 1'b1, "idle_flush_0x200");

        // Flush during beat 2: fill completes but line stays invalid.
        do_fill(32'h0000_0100, 0, 8'hFF, 0, 2, 1'b1);

        // Reset after two beats of a fill.
        pc_if    = 30'h40;
        fetch_en = 1'b1;
        req_q.push_back(28'h10);
        step();
        fetch_en       = 1'b0;
        ic_req_m_ready = 1'b1;
        step();
        ic_req_m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ic_rdat_m_valid = 1'b1;
            wadr_q.push_back(12'(16 + i));
            step();
        end
        ic_rdat_m_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(ic_stall), 0);
        chk("midrst_req_vld", 32'(ic_req_m_valid), 0);
        chk("midrst_wadr", 32'(ic_ram_wadr_all), 0);
        ic_rdat_m_valid = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("stray_beat_wadr", 32'(ic_ram_wadr_all), 0);
        chk("stray_beat_stall", 32'(ic_stall), 0);
        step();
        ic_rdat_m_valid = 1'b0;
        do_fill(32'h0000_0100, 0, 8'hFF, 0, -1, 1'b0);
        probe(32'h0000_0100, 1'b0, "post_rst_hit");

        chk("req_q_drained", 32'(req_q.size()), 0);
        chk("wadr_q_drained", 32'(wadr_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
